id_fwd_scoreboard: RTL and testbench



---
 rtl/id_pkg.sv | 24 ++
 rtl/sb_entry.sv | 35 +++
 rtl/id_fwd_scoreboard.sv | 108 ++++++++++
 tb/tb_id_fwd_scoreboard.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding scoreboard.
package id_pkg;

  typedef enum logic [1:0] {
    LAT_ALU = 2'd0,
    LAT_LD  = 2'd1,
    LAT_MUL = 2'd2
  } lat_class_e;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  // Field width for pos/cnt; NUM_FWD must fit in it.
  localparam int SB_W = 4;

  typedef struct packed {
    logic            busy;
    logic [SB_W-1:0] pos;
    logic [SB_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One register's scoreboard entry: set on issue, age each cycle, clear on retire or EX flush.
module sb_entry
  import id_pkg::*;
#(
  parameter int NUM_FWD = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set,
  input  logic [SB_W-1:0] set_cnt,
  input  logic            flush,
  output sb_entry_t       ent
);

  localparam logic [SB_W-1:0] LAST = SB_W'(NUM_FWD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
    end else if (set) begin
      ent.busy <= 1'b1;
      ent.pos  <= SB_W'(1);
      ent.cnt  <= set_cnt;
    end else if (ent.busy) begin
      // A flush only kills the EX-stage producer; older ones keep aging.
      if ((flush && ent.pos == SB_W'(1)) || ent.pos == LAST) begin
        ent <= '0;
      end else begin
        ent.pos <= ent.pos + SB_W'(1);
        ent.cnt <= (ent.cnt == '0) ? '0 : ent.cnt - SB_W'(1);
      end
    end
  end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Per-register scoreboard driving decode stall, operand forwarding selects and a stall counter.
module id_fwd_scoreboard
  import id_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_FWD  = 3,
  parameter int ALU_LAT  = 1,
  parameter int LD_LAT   = 2,
  parameter int MUL_LAT  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic                         issue_wr,
  input  logic [$clog2(NUM_REGS)-1:0]  issue_rd,
  input  logic [1:0]                   issue_class,
  input  logic [$clog2(NUM_REGS)-1:0]  rs1_idx,
  input  logic [$clog2(NUM_REGS)-1:0]  rs2_idx,
  input  logic                         rs1_used,
  input  logic                         rs2_used,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(NUM_FWD+1)-1:0] fwd_sel_a,
  output logic [$clog2(NUM_FWD+1)-1:0] fwd_sel_b,
  output logic [31:0]                  stall_cycles
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SEL_W = $clog2(NUM_FWD+1);
  localparam int NSLOT = 1 << IDX_W;

  if (NUM_FWD < 1 || NUM_FWD > (1 << SB_W) - 1) begin : g_bad_fwd
    $error("NUM_FWD out of range");
  end
  if (ALU_LAT < 1 || ALU_LAT > NUM_FWD) begin : g_bad_alu
    $error("ALU_LAT must be in 1..NUM_FWD");
  end
  if (LD_LAT < 1 || LD_LAT > NUM_FWD) begin : g_bad_ld
    $error("LD_LAT must be in 1..NUM_FWD");
  end
  if (MUL_LAT < 1 || MUL_LAT > NUM_FWD) begin : g_bad_mul
    $error("MUL_LAT must be in 1..NUM_FWD");
  end

  logic            accept;
  logic [SB_W-1:0] set_cnt;
  logic            haz_a, haz_b;
  sb_entry_t       ents [NSLOT];
  sb_entry_t       ent_a, ent_b;

  assign accept = issue_valid & ~stall & ~flush;

  // Class 3 is illegal and falls back to ALU latency.
  always_comb begin
    case (issue_class)
      LAT_LD:  set_cnt = SB_W'(LD_LAT - 1);
      LAT_MUL: set_cnt = SB_W'(MUL_LAT - 1);
      default: set_cnt = SB_W'(ALU_LAT - 1);
    endcase
  end

  assign ents[0] = '0;

  for (genvar r = 1; r < NSLOT; r++) begin : g_ent
    if (r < NUM_REGS) begin : g_live
      sb_entry #(.NUM_FWD(NUM_FWD)) u_ent (
        .clk     (clk),
        .rst     (rst),
        .set     (accept & issue_wr & (issue_rd == IDX_W'(r))),
        .set_cnt (set_cnt),
        .flush   (flush),
        .ent     (ents[r])
      );
    end else begin : g_none
      assign ents[r] = '0;
    end
  end

  assign ent_a = ents[rs1_idx];
  assign ent_b = ents[rs2_idx];

  // Lookup uses pre-update state, so a same-cycle writer of rd is not seen yet.
  always_comb begin
    haz_a     = 1'b0;
    fwd_sel_a = SEL_W'(FWD_RF);
    if (rs1_used && rs1_idx != '0 && ent_a.busy) begin
      if (ent_a.cnt == '0) fwd_sel_a = ent_a.pos[SEL_W-1:0];
      else                 haz_a     = 1'b1;
    end
  end

  always_comb begin
    haz_b     = 1'b0;
    fwd_sel_b = SEL_W'(FWD_RF);
    if (rs2_used && rs2_idx != '0 && ent_b.busy) begin
      if (ent_b.cnt == '0) fwd_sel_b = ent_b.pos[SEL_W-1:0];
      else                 haz_b     = 1'b1;
    end
  end

  assign stall = issue_valid & ~flush & (haz_a | haz_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Directed checks of stall, forwarding selects and stall counter for the default configuration.
module tb_id_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr, rs1_used, rs2_used, flush;
  logic [4:0]  issue_rd, rs1_idx, rs2_idx;
  logic [1:0]  issue_class;
  logic        stall;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_fwd_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_class  (issue_class),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one decode-stage instruction; inputs change 1ns after the edge.
  task automatic drive(input logic v, input logic wr, input logic [4:0] rd, input logic [1:0] cls,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic fl);
    issue_valid = v;  issue_wr = wr;  issue_rd = rd;  issue_class = cls;
    rs1_idx = r1;     rs1_used = u1;  rs2_idx = r2;   rs2_used = u2;
    flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic chk3(input string tag, input logic s, input logic [1:0] a, input logic [1:0] b);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".sel_a"}, 32'(fwd_sel_a), 32'(a));
    chk({tag, ".sel_b"}, 32'(fwd_sel_b), 32'(b));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk3("reset", 0, 0, 0);
    chk("reset.cnt", stall_cycles, 0);
    rst = 1'b0;
    tick();

    // ALU producer -> next-cycle consumer forwards from EX
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("alu.issue.stall", 32'(stall), 0);
    tick();
    drive(1, 1, 6, 0, 5, 1, 5, 1, 0);
    chk3("alu.dep", 0, 1, 1);
    tick();
    idle(3);
    chk("alu.cnt", stall_cycles, 0);

    // Load-use: one stall, then MEM forward
    drive(1, 1, 7, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 8, 0, 7, 1, 0, 1, 0);
    chk("ld.c1.stall", 32'(stall), 1);
    tick();
    chk3("ld.c2", 0, 2, 0);
    tick();
    chk("ld.cnt", stall_cycles, 1);
    idle(3);

    // Multiply: two stalls, WB forward, then regfile
    drive(1, 1, 9, 2, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 10, 0, 9, 1, 9, 1, 0);
    chk("mul.c1.stall", 32'(stall), 1);
    tick();
    chk("mul.c2.stall", 32'(stall), 1);
    tick();
    chk3("mul.c3", 0, 3, 3);
    tick();
    drive(1, 0, 0, 0, 9, 1, 0, 0, 0);
    chk3("mul.c4", 0, 0, 0);
    chk("mul.cnt", stall_cycles, 3);
    idle(3);

    // Flush kills the EX load; its reader sees the regfile afterwards
    drive(1, 1, 4, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 4, 1, 0, 0, 1);
    chk("flush.c1.stall", 32'(stall), 0);
    tick();
    drive(1, 0, 0, 0, 4, 1, 0, 0, 0);
    chk3("flush.c2", 0, 0, 0);
    chk("flush.cnt", stall_cycles, 3);
    idle(3);

    // Back-to-back writers: youngest (ALU) wins; unused rs2 and x0 give 0
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 3, 1, 3, 0, 0);
    chk3("youngest", 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    chk3("x0", 0, 0, 0);
    idle(3);

    // Same-cycle write and read of rd sees old (empty) entry
    drive(1, 1, 11, 0, 11, 1, 0, 0, 0);
    chk3("samecyc", 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 11, 1, 0, 0, 0);
    chk3("samecyc.next", 0, 1, 0);
    idle(3);

    // Forward position walks EX/MEM/WB then retires
    drive(1, 1, 12, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 12, 1, 12, 1, 0);
    chk3("walk.t1", 0, 1, 1);
    tick();
    chk3("walk.t2", 0, 2, 2);
    tick();
    chk3("walk.t3", 0, 3, 3);
    tick();
    chk3("walk.t4", 0, 0, 0);
    idle(3);

    // Async reset mid-cycle discards a pending load
    drive(1, 1, 13, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 13, 1, 0, 0, 0);
    chk("rst.pre.stall", 32'(stall), 1);
    tick();
    drive(1, 1, 14, 2, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 14, 1, 0, 0, 0);
    chk("rst.pre.cnt", stall_cycles, 4);
    #2 rst = 1'b1;
    #1;
    chk3("rst.mid", 0, 0, 0);
    chk("rst.mid.cnt", stall_cycles, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 14, 1, 13, 1, 0);
    chk3("rst.after", 0, 0, 0);
    chk("rst.after.cnt", stall_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
